// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ memory responder.
//  - data/byte widths and byte-lane constants
//  - default byte address of the output port
//  - loader state encoding
//  - byte-address to word-index helper
package subleq_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LANES      = DATA_W / BYTE_W;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);
    localparam int unsigned WIDX_W     = DATA_W - LANE_IDX_W;

    localparam logic [DATA_W-1:0] IO_ADDR_DEF = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ld_state_t;

    // Full word index of a byte address; callers truncate to their RAM depth.
    function automatic logic [WIDX_W-1:0] word_idx(input logic [DATA_W-1:0] addr);
        return addr[DATA_W-1:LANE_IDX_W];
    endfunction

endpackage

// File: rtl/subleq_mem_resp_if.sv
// Bus bundle between the SUBLEQ core side and the memory responder.
//  mem_rd_*   : core read port (data returned combinationally)
//  mem_wr_*   : core write port
//  core_rst   : reset driven to the core while an image loads
//  ld_*       : byte-stream image loader handshake
//  reload     : request to return to image loading
//  out_*      : output byte stream handshake
// Modports: slave = responder, master = core/loader/sink side.
interface subleq_mem_resp_if;
    import subleq_pkg::*;

    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              core_rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [BYTE_W-1:0] ld_byte;
    logic              ld_last;
    logic              reload;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;

    modport slave (
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  ld_valid, ld_byte, ld_last, reload, out_ready,
        output mem_rd_data, core_rst, ld_ready, out_valid, out_data
    );

    modport master (
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output ld_valid, ld_byte, ld_last, reload, out_ready,
        input  mem_rd_data, core_rst, ld_ready, out_valid, out_data
    );

endinterface

// File: rtl/subleq_out_fifo.sv
// Synchronous first-word-fall-through FIFO for the output byte port.
// Ports:
//  clk, rst   : clock, async active-high reset
//  i_flush    : synchronous clear of all entries
//  i_push     : write i_data (dropped when full unless a pop happens together)
//  i_pop      : remove head entry (ignored when empty)
//  o_valid    : FIFO not empty
//  o_data     : head entry
//  o_count    : number of stored entries
module subleq_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PTR_W'(i)] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/subleq_mem_resp.sv
// Memory responder for the SUBLEQ core: word RAM, byte-stream image loader
// and a byte output port behind a small FIFO.
// After reset the core is held in reset while the loader fills RAM from
// word 0; the byte flagged ld_last releases it. Core addresses are byte
// addresses, each operand is one 32-bit word; writes to IO_ADDR push a byte
// to the output FIFO, reads of IO_ADDR return its free slot count.
// Ports:
//  clk, rst : clock, async active-high reset
//  bus      : subleq_mem_resp_if.slave (core mem port, core_rst, loader,
//             reload, output stream)
// Build option: SUBLEQ_MEM_RELOAD_EN enables reload (RUN -> LOAD, FIFO
// flush, load pointer back to word 0); without it reload is ignored.
module subleq_mem_resp
    import subleq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 10,
    parameter logic [DATA_W-1:0] IO_ADDR     = IO_ADDR_DEF,
    parameter int unsigned       OFIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    subleq_mem_resp_if.slave   bus
);

    localparam int unsigned RAM_DEPTH = 32'd1 << ADDR_W;
    localparam int unsigned CNT_W     = $clog2(OFIFO_DEPTH) + 1;

    ld_state_t          r_state;
    ld_state_t          w_state_nxt;
    logic               r_core_rst;
    logic               w_core_rst_nxt;
    logic               r_ld_ready;
    logic               w_ld_ready_nxt;

    logic [DATA_W-1:0]  r_ram [RAM_DEPTH];
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_wr_word;
    logic [DATA_W-1:0]  w_lane_word;
    logic [LANE_IDX_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_ptr;
    logic               r_wr_pend;

    logic               w_reload;
    logic               w_ld_acc;
    logic               w_word_done;
    logic               w_run;
    logic               w_ram_wr;
    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic [BYTE_W-1:0]  w_out_data;
    logic [CNT_W-1:0]   w_ocount;
    logic [DATA_W-1:0]  w_rd_data;

`ifdef SUBLEQ_MEM_RELOAD_EN
    assign w_reload = (r_state == ST_RUN) && bus.reload;
`else
    logic w_unused_reload;
    assign w_unused_reload = bus.reload;
    assign w_reload        = 1'b0;
`endif

    assign w_ld_acc = (r_state == ST_LOAD) && bus.ld_valid && r_ld_ready;
    // Core port is live only once the final image word is in RAM.
    assign w_run    = (r_state == ST_RUN) && !r_core_rst;

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_core_rst <= 1'b1;
            r_ld_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_ld_ready <= w_ld_ready_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (w_ld_acc && bus.ld_last) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_reload)                w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Output logic. core_rst stays high through the cycle of the final
    // word write so it falls two edges after the ld_last byte.
    always_comb begin
        w_core_rst_nxt = 1'b1;
        w_ld_ready_nxt = 1'b1;
        case (r_state)
            ST_LOAD: begin
                w_ld_ready_nxt = !(w_ld_acc && bus.ld_last);
            end
            ST_RUN: begin
                w_ld_ready_nxt = w_reload;
                w_core_rst_nxt = w_reload || r_wr_pend;
            end
            default: begin
                w_core_rst_nxt = 1'b1;
                w_ld_ready_nxt = 1'b1;
            end
        endcase
    end

    // Place the incoming byte into its lane of the word being assembled.
    always_comb begin
        w_lane_word = r_shift;
        w_lane_word[32'(r_cnt) * BYTE_W +: BYTE_W] = bus.ld_byte;
    end

    assign w_word_done = (r_cnt == LANE_IDX_W'(LANES - 1)) || bus.ld_last;

    // Loader datapath: assemble words, then commit one cycle later at r_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_wr_word <= '0;
            r_wr_pend <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            if (r_wr_pend) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_reload) begin
                r_ptr   <= '0;
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_ld_acc) begin
                if (w_word_done) begin
                    r_wr_word <= w_lane_word;
                    r_wr_pend <= 1'b1;
                    r_shift   <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_shift <= w_lane_word;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_ram_wr = w_run && bus.mem_wr_en && (bus.mem_wr_addr != IO_ADDR);
    assign w_push   = w_run && bus.mem_wr_en && (bus.mem_wr_addr == IO_ADDR);

    // Word RAM: synchronous write, asynchronous read. Loader and core
    // writes never overlap because the core is held in reset while loading.
    always_ff @(posedge clk) begin
        if (r_wr_pend) begin
            r_ram[r_ptr] <= r_wr_word;
        end else if (w_ram_wr) begin
            r_ram[ADDR_W'(word_idx(bus.mem_wr_addr))] <= bus.mem_wr_data;
        end
    end

    // Zero-latency read: the core samples data on the same edge as the address.
    always_comb begin
        w_rd_data = '0;
        if (w_run && bus.mem_rd_en) begin
            if (bus.mem_rd_addr == IO_ADDR) begin
                w_rd_data = DATA_W'(CNT_W'(OFIFO_DEPTH) - w_ocount);
            end else begin
                w_rd_data = r_ram[ADDR_W'(word_idx(bus.mem_rd_addr))];
            end
        end
    end

    assign w_pop = w_out_valid && bus.out_ready;

    subleq_out_fifo #(
        .DEPTH (OFIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_reload),
        .i_push  (w_push),
        .i_data  (bus.mem_wr_data[BYTE_W-1:0]),
        .i_pop   (w_pop),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_count (w_ocount)
    );

    assign bus.mem_rd_data = w_rd_data;
    assign bus.core_rst    = r_core_rst;
    assign bus.ld_ready    = r_ld_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_out_data;

endmodule

// File: tb/tb_subleq_mem_resp.sv
// Bench for subleq_mem_resp: image loading, core reads/writes, output port
// with a queue model of the output FIFO, reload behaviour.
module tb_subleq_mem_resp;
    import subleq_pkg::*;

    localparam logic [31:0] IO     = 32'hFFFF_FFFC;
    localparam int          FDEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subleq_mem_resp_if bus ();

    subleq_mem_resp #(
        .ADDR_W      (10),
        .IO_ADDR     (IO),
        .OFIFO_DEPTH (FDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] exp_q [$];
    bit         in_run  = 1'b0;
    bit         m_pop;
    logic [7:0] m_head;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: just before each active edge, model the FIFO pop/push.
    always @(negedge clk) begin
        #4;
        if (in_run) begin
            m_pop = (exp_q.size() > 0) && bus.out_ready;
            if (m_pop) begin
                m_head = exp_q.pop_front();
                chk("out_valid", 32'(bus.out_valid), 32'd1);
                chk("out_data", 32'(bus.out_data), 32'(m_head));
            end else if (bus.out_valid && bus.out_ready) begin
                chk("out_unexp", 32'(bus.out_data), 32'hDEAD_BEEF);
            end
            if (bus.mem_wr_en && bus.mem_wr_addr == IO && (exp_q.size() < FDEPTH || m_pop))
                exp_q.push_back(bus.mem_wr_data[7:0]);
        end
    end

    task automatic bus_op(input logic re, input logic [31:0] ra,
                          input logic we, input logic [31:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.mem_rd_en   = re;
        bus.mem_rd_addr = ra;
        bus.mem_wr_en   = we;
        bus.mem_wr_addr = wa;
        bus.mem_wr_data = wd;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_op(1'b1, a, 1'b0, 32'd0, 32'd0);
        #1;
        chk(tag, bus.mem_rd_data, exp);
    endtask

    task automatic ld_send(input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            #4;
            if (bus.ld_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("ld_accept", 32'(ok), 32'd1);
    endtask

    // After the ld_last byte: ready drops at once, core_rst falls two edges later.
    task automatic finish_load(input string tag);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        #1;
        chk({tag, "_ready0"}, 32'(bus.ld_ready), 32'd0);
        chk({tag, "_crst_c1"}, 32'(bus.core_rst), 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_crst_c2"}, 32'(bus.core_rst), 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_crst_c3"}, 32'(bus.core_rst), 32'd0);
        in_run = 1'b1;
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    logic [7:0] img2 [5];

    initial begin
        img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        rst             = 1'b1;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_byte     = '0;
        bus.ld_last     = 1'b0;
        bus.reload      = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;

        // Core reads are ignored while loading.
        rd_chk("load_rd_zero", 32'd0, 32'd0);
        bus_op(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Five-byte image: second word partially filled.
        for (int i = 0; i < 5; i++) ld_send(img2[i], i == 4);
        finish_load("img5");
        rd_chk("img5_w0", 32'h0, 32'hDDCC_BBAA);
        rd_chk("img5_w1", 32'h4, 32'h0000_00EE);
        chk("img5_ready_run", 32'(bus.ld_ready), 32'd0);

        // Asynchronous reset in the middle of RUN.
        #1;
        rst    = 1'b1;
        in_run = 1'b0;
        #1;
        chk("arst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("arst_ld_ready", 32'(bus.ld_ready), 32'd1);
        bus.mem_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Twelve-byte image 01..0C.
        for (int i = 0; i < 12; i++) ld_send(8'(i + 1), i == 11);
        finish_load("img12");
        rd_chk("img12_w0", 32'h0, 32'h0403_0201);
        rd_chk("img12_w1", 32'h4, 32'h0807_0605);
        rd_chk("img12_w2", 32'h8, 32'h0C0B_0A09);

        // Write then read back the next cycle; unaligned and aliased reads.
        bus_op(1'b0, 32'd0, 1'b1, 32'h8, 32'h1234);
        rd_chk("raw_next", 32'h8, 32'h0000_1234);
        rd_chk("rd_unaligned", 32'hA, 32'h0000_1234);
        rd_chk("rd_alias", 32'h1008, 32'h0000_1234);
        rd_chk("w1_intact", 32'h4, 32'h0807_0605);
        bus_op(1'b0, 32'h8, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rd_en_low", bus.mem_rd_data, 32'd0);

        // Output port: fifth byte dropped while full.
        rd_chk("io_free_empty", IO, 32'd4);
        for (int i = 0; i < 5; i++) bus_op(1'b0, 32'd0, 1'b1, IO, 32'(8'h41 + i));
        rd_chk("io_free_full", IO, 32'd0);
        bus_op(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        drain("drain1");
        rd_chk("io_free_after", IO, 32'd4);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) bus_op(1'b0, 32'd0, 1'b1, IO, 32'(8'h50 + i));
        bus_op(1'b0, 32'd0, 1'b1, IO, 32'h46);
        bus.out_ready = 1'b1;
        bus_op(1'b1, IO, 1'b0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        #1;
        chk("io_free_pushpop", bus.mem_rd_data, 32'd0);
        bus_op(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        drain("drain2");

        // Reload pulse with one byte pending in the FIFO.
        bus_op(1'b0, 32'd0, 1'b1, IO, 32'h60);
        bus_op(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        bus.reload = 1'b1;
`ifdef SUBLEQ_MEM_RELOAD_EN
        in_run = 1'b0;
        exp_q.delete();
        @(negedge clk);
        bus.reload = 1'b0;
        #1;
        chk("reload_core_rst", 32'(bus.core_rst), 32'd1);
        chk("reload_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reload_ld_ready", 32'(bus.ld_ready), 32'd1);
        ld_send(8'hFF, 1'b1);
        finish_load("reload");
        rd_chk("reload_w0", 32'h0, 32'h0000_00FF);
        rd_chk("reload_w1_kept", 32'h4, 32'h0807_0605);
`else
        @(negedge clk);
        bus.reload = 1'b0;
        #1;
        chk("noreload_core_rst", 32'(bus.core_rst), 32'd0);
        chk("noreload_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("noreload_out_valid", 32'(bus.out_valid), 32'd1);
        drain("drain3");
`endif
        bus_op(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
